// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES block sequencer: default sizes, FSM
// state encoding and the timer width helper.
package aes_ctrl_pkg;

    localparam int BLOCK_W_DEF = 128;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int POP_GAP_DEF = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_BUSY  = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Width of a down-counter able to hold the larger of two load values.
    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. It reports 'expired' during the last counted cycle
// (count == 1) so the owner can leave its state on that same edge.
module cycle_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Load on request, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= W'(0);
        end else if (load) begin
            count_r <= value;
        end else if (count_r != W'(0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == W'(1));

endmodule

// File: rtl/aes_block_sequencer.sv
// Moves 128-bit blocks from the rx buffer through the AES core to the tx
// shifter: pop, start AES, wait for done (with timeout), hand off to tx,
// then idle a few cycles so the buffer head and empty flag settle.
// All outputs are registered; pulses are decided from the next state.
module aes_block_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int POP_GAP = POP_GAP_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               clr_err,
    input  logic [BLOCK_W-1:0] buf_dout,
    input  logic               buf_empty,
    input  logic               buf_overflow,
    output logic               buf_read_en,
    output logic [BLOCK_W-1:0] aes_din,
    output logic               aes_start,
    input  logic [BLOCK_W-1:0] aes_dout,
    input  logic               aes_done,
    output logic [BLOCK_W-1:0] tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               busy,
    output logic [CNT_W-1:0]   blocks_done,
    output logic               err_timeout,
    output logic               err_overflow
);

    localparam int               TMR_W       = timer_width(TIMEOUT, POP_GAP);
    localparam logic [TMR_W-1:0] TMR_TIMEOUT = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_POP_GAP = TMR_W'(POP_GAP);

    logic [2:0]         state_r;
    logic [2:0]         next_state_s;

    logic               timer_load_s;
    logic [TMR_W-1:0]   timer_val_s;
    logic               timer_expired_s;

    logic               read_en_s;
    logic               aes_start_s;
    logic               tx_start_s;
    logic               busy_s;
    logic               timeout_s;
    logic [BLOCK_W-1:0] tx_src_s;

    logic               buf_read_en_r;
    logic               aes_start_r;
    logic               tx_start_r;
    logic               busy_r;
    logic [BLOCK_W-1:0] data_r;
    logic [BLOCK_W-1:0] res_r;
    logic [BLOCK_W-1:0] tx_data_r;
    logic [CNT_W-1:0]   blocks_done_r;
    logic               err_timeout_r;
    logic               err_overflow_r;

    // One timer serves both the AES timeout window and the post-pop gap.
    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load_s),
        .value   (timer_val_s),
        .expired (timer_expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decision; a completing AES wins over a same-cycle timeout,
    // and SEND leaves only after its tx_start pulse has been issued.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && !buf_empty) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: next_state_s = ST_START;
            ST_START: next_state_s = ST_BUSY;
            ST_BUSY: begin
                if (aes_done) begin
                    next_state_s = ST_SEND;
                end else if (timer_expired_s) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_SEND: begin
                if (tx_start_r) begin
                    next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (timer_expired_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the timer controls.
    always_comb begin
        read_en_s    = (next_state_s == ST_FETCH);
        aes_start_s  = (next_state_s == ST_START);
        tx_start_s   = (next_state_s == ST_SEND) && !tx_busy;
        busy_s       = (next_state_s != ST_IDLE);
        timeout_s    = (state_r == ST_BUSY) && !aes_done && timer_expired_s;
        timer_load_s = (next_state_s == ST_START) ||
                       ((next_state_s == ST_GAP) && (state_r != ST_GAP));
        if (next_state_s == ST_START) begin
            timer_val_s = TMR_TIMEOUT;
        end else begin
            timer_val_s = TMR_POP_GAP;
        end
        // On the BUSY->SEND edge res_r is not loaded yet, so take the core output.
        if (state_r == ST_BUSY) begin
            tx_src_s = aes_dout;
        end else begin
            tx_src_s = res_r;
        end
    end

    // Output pulse and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_read_en_r <= 1'b0;
            aes_start_r   <= 1'b0;
            tx_start_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            buf_read_en_r <= read_en_s;
            aes_start_r   <= aes_start_s;
            tx_start_r    <= tx_start_s;
            busy_r        <= busy_s;
        end
    end

    // Block data path: fetched block, AES result and block handed to tx.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r    <= {BLOCK_W{1'b0}};
            res_r     <= {BLOCK_W{1'b0}};
            tx_data_r <= {BLOCK_W{1'b0}};
        end else begin
            if (state_r == ST_FETCH) begin
                data_r <= buf_dout;
            end
            if ((state_r == ST_BUSY) && aes_done) begin
                res_r <= aes_dout;
            end
            if (tx_start_s) begin
                tx_data_r <= tx_src_s;
            end
        end
    end

    // Count of blocks handed to tx; wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blocks_done_r <= {CNT_W{1'b0}};
        end else if (tx_start_s) begin
            blocks_done_r <= blocks_done_r + CNT_W'(1);
        end else begin
            blocks_done_r <= blocks_done_r;
        end
    end

    // Sticky error flags; a new error in the clearing cycle stays set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_r  <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end else if (clr_err) begin
                err_timeout_r <= 1'b0;
            end
            if (buf_overflow) begin
                err_overflow_r <= 1'b1;
            end else if (clr_err) begin
                err_overflow_r <= 1'b0;
            end
        end
    end

    assign buf_read_en  = buf_read_en_r;
    assign aes_start    = aes_start_r;
    assign tx_start     = tx_start_r;
    assign busy         = busy_r;
    assign aes_din      = data_r;
    assign tx_data      = tx_data_r;
    assign blocks_done  = blocks_done_r;
    assign err_timeout  = err_timeout_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer. A small buffer model, AES model
// and pulse monitors run on the falling edge; the directed sequence samples
// one time unit after the falling edge. The block counter is instantiated
// 3 bits wide so its wrap is reached with a handful of blocks.
module tb_aes_block_sequencer;

    localparam int BW = 128;
    localparam int CW = 3;
    localparam int TO = 64;
    localparam int PG = 4;

    localparam logic [BW-1:0] KEY = {4{32'h0F0F_0F0F}};

    logic          clk = 1'b0;
    logic          reset_n, enable, clr_err, buf_overflow, tx_busy;
    logic          buf_empty, buf_read_en, aes_start, tx_start, busy;
    logic          err_timeout, err_overflow;
    logic          aes_done = 1'b0;
    logic [BW-1:0] buf_dout, aes_din, tx_data;
    logic [BW-1:0] aes_dout = '0;
    logic [CW-1:0] blocks_done;

    int checks = 0;
    int failures = 0;

    aes_block_sequencer #(
        .BLOCK_W (BW), .TIMEOUT (TO), .POP_GAP (PG), .CNT_W (CW)
    ) dut (
        .clk (clk), .reset_n (reset_n), .enable (enable), .clr_err (clr_err),
        .buf_dout (buf_dout), .buf_empty (buf_empty), .buf_overflow (buf_overflow),
        .buf_read_en (buf_read_en), .aes_din (aes_din), .aes_start (aes_start),
        .aes_dout (aes_dout), .aes_done (aes_done), .tx_data (tx_data),
        .tx_start (tx_start), .tx_busy (tx_busy), .busy (busy),
        .blocks_done (blocks_done), .err_timeout (err_timeout),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: head advances one cycle after the pop pulse is seen.
    logic [BW-1:0] mem [0:31];
    logic [4:0]    wr_ptr = 5'd0;
    logic [4:0]    rd_ptr = 5'd0;
    logic          pend = 1'b0;
    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_dout  = mem[rd_ptr];

    // AES model settings, written by the directed sequence.
    int            aes_lat  = 0;
    logic          xor_mode = 1'b0;
    logic [BW-1:0] fixed_res = '0;
    int            aes_cnt  = 0;
    int            n_done   = 0;
    int            done_cyc = 0;

    int            n_pop = 0, n_start = 0, n_tx = 0, n_multi = 0;
    int            start_cyc = 0, tx_cyc = 0;
    int            pop_cyc[$];
    logic [BW-1:0] txq[$];

    // AES model: done pulse aes_lat cycles after start (aes_lat 0 = never).
    always @(negedge clk) begin
        if (aes_cnt == 1) begin
            aes_done <= 1'b1;
            aes_dout <= xor_mode ? (aes_din ^ KEY) : fixed_res;
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end else begin
            aes_done <= 1'b0;
        end
        if (aes_start && aes_lat != 0) aes_cnt <= aes_lat;
        else if (aes_cnt != 0)         aes_cnt <= aes_cnt - 1;
    end

    // Buffer pop and output pulse monitors.
    always @(negedge clk) begin
        pend <= buf_read_en;
        if (pend) rd_ptr <= rd_ptr + 5'd1;
        if (buf_read_en) begin
            n_pop <= n_pop + 1;
            pop_cyc.push_back(cyc);
        end
        if (aes_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (tx_start) begin
            n_tx   <= n_tx + 1;
            tx_cyc <= cyc;
            txq.push_back(tx_data);
        end
        if ((int'(buf_read_en) + int'(aes_start) + int'(tx_start)) > 1) n_multi <= n_multi + 1;
    end

    task automatic chk_w(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    function automatic logic [BW-1:0] txq_at(input int i);
        if (i < txq.size()) return txq[i];
        return {BW{1'bx}};
    endfunction

    task automatic wait_tx(input string tag, input int target, input int budget);
        int k = 0;
        while (n_tx < target && k < budget) begin
            step();
            k++;
        end
        chk_i(tag, int'(n_tx >= target), 1);
    endtask

    task automatic wait_start(input string tag, input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            step();
            k++;
        end
        chk_i(tag, int'(n_start >= target), 1);
    endtask

    task automatic wait_idle(input int budget, output int k);
        k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_i({tag, "_busy"}, int'(busy), 0);
        chk_i({tag, "_pulses"}, int'({buf_read_en, aes_start, tx_start}), 0);
        chk_i({tag, "_blocks"}, int'(blocks_done), 0);
        chk_i({tag, "_errs"}, int'({err_timeout, err_overflow}), 0);
        chk_w({tag, "_aes_din"}, aes_din, '0);
        chk_w({tag, "_tx_data"}, tx_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s, base, p0, bad, min_gap, d0;
        reset_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
        buf_overflow = 1'b0; tx_busy = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Single block with fixed AES result after 10 cycles.
        enable = 1'b1; xor_mode = 1'b0; fixed_res = {16{8'hA5}}; aes_lat = 10;
        push(128'h00112233_44556677_8899AABB_CCDDEEFF);
        step();
        chk_i("t1_pop_latency", int'(buf_read_en), 1);
        step();
        chk_i("t1_start_latency", int'(aes_start), 1);
        chk_w("t1_aes_din", aes_din, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        wait_tx("t1_wait_tx", 1, 40);
        chk_w("t1_tx_data", txq_at(0), {16{8'hA5}});
        chk_i("t1_tx_latency", tx_cyc - done_cyc, 1);
        wait_idle(20, k);
        chk_i("t1_pops", n_pop, 1);
        chk_i("t1_starts", n_start, 1);
        chk_i("t1_blocks", int'(blocks_done), 1);

        // Three queued blocks, result = block ^ KEY.
        xor_mode = 1'b1; aes_lat = 5;
        push({4{32'h1111_1111}});
        push({4{32'h2222_2222}});
        push({4{32'h3333_3333}});
        wait_tx("t2_wait_tx", 4, 200);
        wait_idle(20, k);
        chk_w("t2_tx0", txq_at(1), {4{32'h1E1E_1E1E}});
        chk_w("t2_tx1", txq_at(2), {4{32'h2D2D_2D2D}});
        chk_w("t2_tx2", txq_at(3), {4{32'h3C3C_3C3C}});
        chk_i("t2_blocks", int'(blocks_done), 4);
        chk_i("t2_pops", n_pop, 4);
        min_gap = 1000;
        for (int i = 1; i < pop_cyc.size(); i++) begin
            if (pop_cyc[i] - pop_cyc[i-1] < min_gap) min_gap = pop_cyc[i] - pop_cyc[i-1];
        end
        chk_i("t2_pop_gap_ok", int'(min_gap >= PG + 3), 1);

        // AES never completes: timeout, dropped block, gap, then clear.
        aes_lat = 0;
        push({4{32'hDEAD_BEEF}});
        wait_start("t3_wait_start", n_start + 1, 20);
        s = start_cyc;
        k = 0;
        while (!err_timeout && k < 100) begin
            step();
            k++;
        end
        chk_i("t3_timeout_cycles", cyc - s, TO);
        wait_idle(20, k);
        chk_i("t3_gap_len", k, PG);
        chk_i("t3_no_tx", n_tx, 4);
        chk_i("t3_blocks", int'(blocks_done), 4);
        chk_i("t3_err_held", int'(err_timeout), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk_i("t3_err_cleared", int'(err_timeout), 0);

        // tx backpressure for 20 cycles after aes_done.
        xor_mode = 1'b0; fixed_res = {4{32'hCAFE_F00D}}; aes_lat = 3; tx_busy = 1'b1;
        d0 = n_done;
        push({4{32'h5555_5555}});
        k = 0;
        while (n_done == d0 && k < 30) begin
            step();
            k++;
        end
        chk_i("t4_done_seen", int'(n_done > d0), 1);
        bad = 0;
        repeat (20) begin
            step();
            if (tx_start || !busy) bad++;
        end
        chk_i("t4_hold_send", bad, 0);
        tx_busy = 1'b0;
        step();
        chk_i("t4_tx_start", int'(tx_start), 1);
        chk_w("t4_tx_data", tx_data, {4{32'hCAFE_F00D}});
        chk_i("t4_blocks", int'(blocks_done), 5);
        wait_idle(20, k);

        // Asynchronous reset while BUSY.
        aes_lat = 0;
        push({4{32'h6666_6666}});
        wait_start("t5_wait_start", n_start + 1, 20);
        repeat (5) step();
        chk_i("t5_busy_before", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        step();
        step();
        reset_n = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (busy) bad++;
        end
        chk_i("t5_idle_after", bad, 0);

        // Counter wrap, enable gating, overflow set-wins-over-clear.
        xor_mode = 1'b1; aes_lat = 2;
        base = n_tx;
        for (int i = 0; i < 7; i++) push({16{8'(i + 1)}});
        wait_tx("t6_wait_seven", base + 7, 400);
        wait_idle(20, k);
        chk_i("t6_blocks_max", int'(blocks_done), 7);
        enable = 1'b0;
        p0 = n_pop;
        push({4{32'h4444_4444}});
        repeat (12) step();
        chk_i("t6_no_fetch_disabled", n_pop, p0);
        enable = 1'b1;
        wait_tx("t6_wait_last", base + 8, 60);
        chk_w("t6_tx_last", tx_data, {4{32'h4B4B_4B4B}});
        wait_idle(20, k);
        chk_i("t6_blocks_wrap", int'(blocks_done), 0);
        buf_overflow = 1'b1; clr_err = 1'b1;
        step();
        buf_overflow = 1'b0; clr_err = 1'b0;
        chk_i("t6_ovf_set_wins", int'(err_overflow), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk_i("t6_ovf_cleared", int'(err_overflow), 0);

        chk_i("onehot_pulses", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
